adder_share_arb: RTL and testbench
==================================

// Module: adder_share_arb
// PURPOSE
//   Time-shares one WIDTH-bit adder (sum + overflow "stat") between two requesters.
//   Round-robin arbitration, valid/ready handshake on both sides, registered result.
//   Sits between the counter/accumulator clients and the shared adder datapath.
// PARAMETERS
//   WIDTH   2  operand/sum width in bits
//   STAT_W  8  overflow-counter width (used only with ADD_ARB_OVF_CNT_EN)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        reset, asynchronous, active-low
//   req_valid  in   2        bit i: requester i offers operands
//   req_ready  out  2        bit i: requester i's operands accepted this cycle
//   req0_a     in   WIDTH    requester 0 operand a
//   req0_b     in   WIDTH    requester 0 operand b
//   req1_a     in   WIDTH    requester 1 operand a
//   req1_b     in   WIDTH    requester 1 operand b
//   rsp_valid  out  1        result available
//   rsp_ready  in   1        consumer takes result
//   rsp_id     out  1        requester that owns the result
//   rsp_sum    out  WIDTH    (a+b) mod 2^WIDTH
//   rsp_stat   out  1        carry out of MSB (overflow)
//   busy       out  1        state != IDLE
//   ovf_cnt    out  STAT_W   overflow count (only with ADD_ARB_OVF_CNT_EN)
// BEHAVIOUR
//   FSM: IDLE -> CALC -> RESP -> IDLE. One operation in flight.
//   IDLE: if any req_valid, pick winner; req_ready[winner]=1 combinationally that
//     cycle (Moore on state, Mealy on req_valid); latch a,b,id; -> CALC. Else stay.
//   Arbitration: one valid -> it wins; both valid -> prio wins. prio resets to 0;
//     on RESP handshake prio <= ~winner. req_ready is one-hot or zero, never both.
//   CALC: {stat,sum} = a + b, (WIDTH+1)-bit; register into rsp_*; rsp_valid<=1; -> RESP.
//   RESP: hold rsp_valid/id/sum/stat stable until rsp_ready; on rsp_valid&rsp_ready
//     clear rsp_valid, update prio, -> IDLE. No req_ready asserted in CALC/RESP.
//   Latency: accept in cycle N -> rsp_valid first high in cycle N+2. Max rate one
//     op per 3 cycles with rsp_ready held high.
//   Wrap: 3+1 -> sum 0 stat 1; 3+3 -> sum 2 stat 1; 0+0 -> sum 0 stat 0.
//   Requester dropping req_valid while not granted: legal, no effect.
//   Reset (any state, incl. mid-CALC/RESP): state IDLE, prio 0, req_ready 0,
//     rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_stat 0, busy 0, ovf_cnt 0; in-flight op lost.
// CONFIGURATION
//   ADD_ARB_OVF_CNT_EN defined: ovf_cnt port present; increments on each RESP
//     handshake with rsp_stat=1; saturates at all-ones; cleared only by reset.
//   Not defined: ovf_cnt port and counter absent; STAT_W ignored; rest unchanged.
// STRUCTURE
//   Package add_arb_pkg: state enum typedef (IDLE/CALC/RESP), REQ0/REQ1 id constants.
//   Sub-module rr_pick2: inputs req_valid[1:0], prio; outputs one-hot grant, id.
//   Adder is a single registered expression in CALC; no other sub-modules.
// TESTING
//   1 req0 a=1 b=1 alone -> req_ready=2'b01 cycle N; rsp_valid cycle N+2, sum=2 stat=0 id=0.
//   2 req1 a=3 b=1 -> sum=0 stat=1 id=1; then a=3 b=3 -> sum=2 stat=1.
//   3 both req_valid held high, rsp_ready=1 -> grant order 0,1,0,1 after reset.
//   4 rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout, busy=1.
//   5 rst_n low during CALC -> all outputs 0 immediately (async); next op grants req0.
//   6 with ADD_ARB_OVF_CNT_EN, STAT_W=2: 4 overflowing ops -> ovf_cnt 1,2,3,3.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared types for the two-requester adder arbiter: FSM states and requester ids.
package add_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/adder_share_arb_rr_pick2.sv
// Two-way round-robin picker: purely combinational, zero latency.
// No backpressure; a lone requester always wins and prio breaks ties.
module rr_pick2
    import add_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       id
);
    always_comb begin
        grant = 2'b00;
        id    = REQ0;
        case (req_valid)
            2'b01: begin
                grant = 2'b01;
                id    = REQ0;
            end
            2'b10: begin
                grant = 2'b10;
                id    = REQ1;
            end
            2'b11: begin
                grant = prio ? 2'b10 : 2'b01;
                id    = prio;
            end
            default: begin
                grant = 2'b00;
                id    = REQ0;
            end
        endcase
    end
endmodule

// File: rtl/adder_share_arb.sv
// Shares one WIDTH-bit adder between two requesters; optional overflow counter via ADD_ARB_OVF_CNT_EN.
// Latency: accept in cycle N, rsp_valid in cycle N+2; one op in flight, max one op per 3 cycles.
// Backpressure: rsp_ready low holds the result stable and keeps both req_ready low.
module adder_share_arb
    import add_arb_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_sum,
    output logic              rsp_stat,
    output logic              busy
`ifdef ADD_ARB_OVF_CNT_EN
    ,
    output logic [STAT_W-1:0] ovf_cnt
`endif
);
    state_t           state;
    logic             prio;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic [1:0]       grant;
    logic             win_id;

    rr_pick2 u_pick (
        .req_valid (req_valid),
        .prio      (prio),
        .grant     (grant),
        .id        (win_id)
    );

    // Grant is only offered while idle and out of reset, so it is zero during reset too.
    assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= REQ0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= REQ0;
            rsp_valid <= 1'b0;
            rsp_id    <= REQ0;
            rsp_sum   <= '0;
            rsp_stat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        a_q   <= (win_id == REQ1) ? req1_a : req0_a;
                        b_q   <= (win_id == REQ1) ? req1_b : req0_b;
                        id_q  <= win_id;
                        state <= CALC;
                    end
                end
                CALC: begin
                    {rsp_stat, rsp_sum} <= {1'b0, a_q} + {1'b0, b_q};
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        prio      <= ~rsp_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_ARB_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (state == RESP && rsp_valid && rsp_ready && rsp_stat && ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    // STAT_W only sizes the overflow counter, which is absent in this build.
    if (STAT_W > 0) begin : g_stat_w_unused
    end
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios then random traffic against a transaction-level model.
module tb_adder_share_arb;
    localparam int WIDTH  = 2;
    localparam int STAT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_sum;
    logic              rsp_stat;
    logic              busy;
`ifdef ADD_ARB_OVF_CNT_EN
    logic [STAT_W-1:0] ovf_cnt;
`endif

    adder_share_arb #(.WIDTH(WIDTH), .STAT_W(STAT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_stat  (rsp_stat),
        .busy      (busy)
`ifdef ADD_ARB_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: is an op outstanding, how old is it, what must it return.
    bit m_busy;
    int m_age;
    bit m_prio;
    int m_id, m_sum, m_stat;
    int m_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_prio = 0;
        m_id = 0; m_sum = 0; m_stat = 0; m_cnt = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id",    int'(rsp_id),    0);
        chk("rst_rsp_sum",   int'(rsp_sum),   0);
        chk("rst_rsp_stat",  int'(rsp_stat),  0);
        chk("rst_busy",      int'(busy),      0);
`ifdef ADD_ARB_OVF_CNT_EN
        chk("rst_ovf_cnt",   int'(ovf_cnt),   0);
`endif
    endtask

    // One clock: drive inputs just after a rising edge, check at the falling edge.
    task automatic cyc(input logic [1:0] rv, input int a0, input int b0,
                       input int a1, input int b1, input logic rr);
        int exp_rdy;
        int winner;
        bit exp_vld;
        req_valid = rv;
        req0_a = WIDTH'(a0); req0_b = WIDTH'(b0);
        req1_a = WIDTH'(a1); req1_b = WIDTH'(b1);
        rsp_ready = rr;
        @(negedge clk);
        exp_rdy = 0;
        winner  = 0;
        if (!m_busy && rv != 2'b00) begin
            if (rv == 2'b11) winner = m_prio ? 1 : 0;
            else             winner = (rv == 2'b10) ? 1 : 0;
            exp_rdy = 1 << winner;
        end
        exp_vld = m_busy && (m_age >= 2);
        chk("req_ready", int'(req_ready), exp_rdy);
        chk("rsp_valid", int'(rsp_valid), int'(exp_vld));
        chk("busy",      int'(busy),      int'(m_busy));
        if (exp_vld) begin
            chk("rsp_id",   int'(rsp_id),   m_id);
            chk("rsp_sum",  int'(rsp_sum),  m_sum);
            chk("rsp_stat", int'(rsp_stat), m_stat);
        end
`ifdef ADD_ARB_OVF_CNT_EN
        chk("ovf_cnt", int'(ovf_cnt), m_cnt);
`endif
        if (exp_rdy != 0) begin
            int total;
            total  = (winner == 1) ? (a1 + b1) : (a0 + b0);
            m_busy = 1;
            m_age  = 1;
            m_id   = winner;
            m_sum  = total % (1 << WIDTH);
            m_stat = (total >= (1 << WIDTH)) ? 1 : 0;
        end else if (m_busy) begin
            if (exp_vld && rr) begin
                m_busy = 0;
                m_prio = (m_id == 0);
                if (m_stat == 1 && m_cnt < (1 << STAT_W) - 1) m_cnt++;
            end else if (m_age < 2) begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        do_reset();

        // Lone requester 0: 1+1.
        cyc(2'b01, 1, 1, 0, 0, 1'b1);
        cyc(2'b00, 0, 0, 0, 0, 1'b1);
        cyc(2'b00, 0, 0, 0, 0, 1'b1);
        cyc(2'b00, 0, 0, 0, 0, 1'b1);

        // Lone requester 1: wrap cases 3+1 and 3+3, then 0+0.
        for (int i = 0; i < 3; i++) cyc(2'b10, 0, 0, 3, 1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(2'b10, 0, 0, 3, 3, 1'b1);
        for (int i = 0; i < 3; i++) cyc(2'b01, 0, 0, 0, 0, 1'b1);

        // Both held high from reset: grants alternate 0,1,0,1.
        do_reset();
        for (int i = 0; i < 12; i++) cyc(2'b11, 1, 2, 2, 3, 1'b1);

        // Consumer stalls five cycles in RESP while both keep requesting.
        cyc(2'b11, 2, 3, 3, 2, 1'b0);
        for (int i = 0; i < 6; i++) cyc(2'b11, 0, 1, 1, 0, 1'b0);
        cyc(2'b11, 0, 1, 1, 0, 1'b1);
        cyc(2'b00, 0, 0, 0, 0, 1'b1);

        // Asynchronous reset in the middle of CALC, then requester 0 must win a tie.
        do_reset();
        cyc(2'b10, 0, 0, 3, 3, 1'b1);
        cyc(2'b10, 0, 0, 3, 3, 1'b1);
        cyc(2'b10, 0, 0, 3, 3, 1'b1);
        cyc(2'b11, 1, 0, 2, 2, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(2'b11, 1, 2, 3, 3, 1'b1);

        // Four overflowing ops from reset; the 2-bit counter saturates at 3.
        do_reset();
        for (int i = 0; i < 12; i++) cyc(2'b01, 3, 3, 0, 0, 1'b1);
        cyc(2'b00, 0, 0, 0, 0, 1'b1);

        // Random traffic with random consumer backpressure.
        for (int i = 0; i < 400; i++) begin
            cyc(2'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
